// File: rtl/sim_ctrl.sv
// Simulation run controller: core reset sequencing, cycle budget, drain and verdict.
// Optional SIM_FINISH_EN: report the verdict and end simulation one cycle after done.
module sim_ctrl #(
  parameter int RESET_CYCLES = 4,
  parameter int MAX_CYCLES   = 10000,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt,
  input  logic             error,
  output logic             core_reset,
  output logic             running,
  output logic [CNT_W-1:0] cycle_count,
  output logic             done,
  output logic             timeout,
  output logic             pass
);

  typedef enum logic [1:0] {
    HOLD,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CYCLES);

  state_t           state;
  logic [31:0]      hold_cnt;
  logic [31:0]      drain_cnt;
  logic             err_flag;
  logic [CNT_W-1:0] cnt_inc;
  logic             hold_last;
  logic             drain_last;
  logic             stop;

  assign cnt_inc    = (&cycle_count) ? cycle_count
                                     : cycle_count + 1'b1;
  assign hold_last  = (hold_cnt + 32'd1) >= 32'(RESET_CYCLES);
  assign drain_last = (drain_cnt + 32'd1) >= 32'(DRAIN_CYCLES);
  assign stop       = halt | error;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      drain_cnt   <= '0;
      err_flag    <= 1'b0;
      core_reset  <= 1'b1;
      running     <= 1'b0;
      cycle_count <= '0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      pass        <= 1'b0;
    end else begin
      unique case (state)
        HOLD: begin
          hold_cnt <= hold_cnt + 32'd1;
          if (hold_last) begin
            state      <= RUN;
            core_reset <= 1'b0;
            running    <= 1'b1;
          end
        end
        RUN: begin
          cycle_count <= cnt_inc;
          err_flag    <= err_flag | error;
          // a stop request on the exhaustion edge takes the drain path
          if (stop) begin
            state     <= DRAIN;
            running   <= 1'b0;
            drain_cnt <= '0;
          end else if (cnt_inc == CNT_MAX) begin
            state      <= DONE;
            running    <= 1'b0;
            core_reset <= 1'b1;
            done       <= 1'b1;
            timeout    <= 1'b1;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 32'd1;
          err_flag  <= err_flag | error;
          if (drain_last) begin
            state      <= DONE;
            core_reset <= 1'b1;
            done       <= 1'b1;
            pass       <= ~(err_flag | error);
          end
        end
        DONE: begin
        end
        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

`ifdef SIM_FINISH_EN
  logic done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done;
      if (done && !done_q) begin
        $display("sim_ctrl: cycle_count=%0d pass=%0b timeout=%0b",
                 cycle_count, pass, timeout);
        $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sim_ctrl.sv
// Bench for sim_ctrl: directed vector table, hand sequences and a
// randomized run checked against an event-time reference model.
module tb_sim_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halt = 1'b0;
  logic err = 1'b0;

  logic [2:0]  cr, rn, dn, to, ps;
  logic [31:0] cc0, cc1;
  logic [7:0]  cc2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sim_ctrl #(.RESET_CYCLES(4), .MAX_CYCLES(50),
             .DRAIN_CYCLES(2), .CNT_W(32)) u_d0 (
    .clk(clk), .reset(rst), .halt(halt), .error(err),
    .core_reset(cr[0]), .running(rn[0]), .cycle_count(cc0),
    .done(dn[0]), .timeout(to[0]), .pass(ps[0]));

  sim_ctrl #(.RESET_CYCLES(4), .MAX_CYCLES(30),
             .DRAIN_CYCLES(2), .CNT_W(32)) u_d1 (
    .clk(clk), .reset(rst), .halt(halt), .error(err),
    .core_reset(cr[1]), .running(rn[1]), .cycle_count(cc1),
    .done(dn[1]), .timeout(to[1]), .pass(ps[1]));

  sim_ctrl #(.RESET_CYCLES(0), .MAX_CYCLES(5),
             .DRAIN_CYCLES(0), .CNT_W(8)) u_d2 (
    .clk(clk), .reset(rst), .halt(halt), .error(err),
    .core_reset(cr[2]), .running(rn[2]), .cycle_count(cc2),
    .done(dn[2]), .timeout(to[2]), .pass(ps[2]));

  localparam int RP[3] = '{4, 4, 0};
  localparam int MP[3] = '{50, 30, 5};
  localparam int DP[3] = '{2, 2, 0};

  // Model: t = non-reset edges seen; stop_t/fin_t = edge numbers of
  // the stop event and of entering DONE (-1 while still unknown).
  typedef struct {
    int t;
    int stop_t;
    int fin_t;
    bit err;
    bit by_to;
    int cnt;
  } mdl_t;

  mdl_t m[3];

  function automatic int run_begin(int r);
    return (r < 1) ? 1 : r;
  endfunction

  function automatic mdl_t mstep(mdl_t s, bit r, bit h, bit e,
                                 int rc, int mc, int dc);
    bit in_run, in_drain;
    if (r) begin
      s = '{t:0, stop_t:-1, fin_t:-1, err:0, by_to:0, cnt:0};
      return s;
    end
    in_run   = (s.t >= run_begin(rc)) && (s.stop_t < 0);
    in_drain = (s.stop_t >= 0) && (s.t < s.fin_t);
    if (in_run || in_drain) s.err = s.err | e;
    s.t = s.t + 1;
    if (in_run) begin
      s.cnt = s.cnt + 1;
      if (h || e) begin
        s.stop_t = s.t;
        s.fin_t  = s.t + ((dc < 1) ? 1 : dc);
      end else if (s.cnt == mc) begin
        s.stop_t = s.t;
        s.fin_t  = s.t;
        s.by_to  = 1'b1;
      end
    end
    return s;
  endfunction

  function automatic logic [4:0] mflags(mdl_t s, int rc);
    bit hold, run, fin;
    hold = s.t < run_begin(rc);
    run  = !hold && (s.stop_t < 0);
    fin  = (s.stop_t >= 0) && (s.t >= s.fin_t);
    return {hold | fin, run, fin, fin && s.by_to,
            fin && !s.by_to && !s.err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dcnt(int i);
    case (i)
      0: return cc0;
      1: return cc1;
      default: return {24'd0, cc2};
    endcase
  endfunction

  task automatic cmp_models();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model%0d.flags", i),
          {27'd0, cr[i], rn[i], dn[i], to[i], ps[i]},
          {27'd0, mflags(m[i], RP[i])});
      chk($sformatf("model%0d.cnt", i), dcnt(i), m[i].cnt);
    end
  endtask

  task automatic step(input bit r, input bit h, input bit e);
    rst = r;
    halt = h;
    err = e;
    @(posedge clk);
    for (int i = 0; i < 3; i++)
      m[i] = mstep(m[i], r, h, e, RP[i], MP[i], DP[i]);
    @(negedge clk);
    cmp_models();
  endtask

  task automatic chk_dut(input string name, input int i,
                         input logic [4:0] f, input int c);
    chk({name, ".flags"},
        {27'd0, cr[i], rn[i], dn[i], to[i], ps[i]}, {27'd0, f});
    chk({name, ".cnt"}, dcnt(i), c);
  endtask

  typedef struct {
    int n;
    bit r, h, e;
    bit cr, rn, dn, to, ps;
    int cnt;
  } vec_t;

  vec_t tbl[34];

  initial begin
    tbl = '{
      '{2, 1,0,0, 1,0,0,0,0, 0},
      '{3, 0,0,0, 1,0,0,0,0, 0},
      '{1, 0,0,0, 0,1,0,0,0, 0},
      '{1, 0,0,0, 0,1,0,0,0, 1},
      '{1, 0,0,0, 0,1,0,0,0, 2},
      '{18,0,0,0, 0,1,0,0,0, 20},
      '{1, 0,1,0, 0,0,0,0,0, 21},
      '{1, 0,0,0, 0,0,0,0,0, 21},
      '{1, 0,0,0, 1,0,1,0,1, 21},
      '{3, 0,1,1, 1,0,1,0,1, 21},
      '{1, 1,0,0, 1,0,0,0,0, 0},
      '{4, 0,0,0, 0,1,0,0,0, 0},
      '{10,0,0,0, 0,1,0,0,0, 10},
      '{1, 0,1,1, 0,0,0,0,0, 11},
      '{2, 0,0,0, 1,0,1,0,0, 11},
      '{1, 1,0,0, 1,0,0,0,0, 0},
      '{4, 0,0,0, 0,1,0,0,0, 0},
      '{5, 0,0,0, 0,1,0,0,0, 5},
      '{1, 0,1,0, 0,0,0,0,0, 6},
      '{1, 0,0,1, 0,0,0,0,0, 6},
      '{1, 0,0,0, 1,0,1,0,0, 6},
      '{1, 1,0,0, 1,0,0,0,0, 0},
      '{4, 0,0,0, 0,1,0,0,0, 0},
      '{49,0,0,0, 0,1,0,0,0, 49},
      '{1, 0,0,0, 1,0,1,1,0, 50},
      '{5, 0,0,0, 1,0,1,1,0, 50},
      '{1, 1,0,0, 1,0,0,0,0, 0},
      '{4, 0,0,0, 0,1,0,0,0, 0},
      '{10,0,0,0, 0,1,0,0,0, 10},
      '{1, 0,1,0, 0,0,0,0,0, 11},
      '{1, 1,0,0, 1,0,0,0,0, 0},
      '{3, 0,0,0, 1,0,0,0,0, 0},
      '{1, 0,0,0, 0,1,0,0,0, 0},
      '{1, 0,0,0, 0,1,0,0,0, 1}
    };

    @(negedge clk);

    for (int k = 0; k < 34; k++) begin
      for (int j = 0; j < tbl[k].n; j++)
        step(tbl[k].r, tbl[k].h, tbl[k].e);
      chk_dut($sformatf("vec%0d", k), 0,
              {tbl[k].cr, tbl[k].rn, tbl[k].dn,
               tbl[k].to, tbl[k].ps}, tbl[k].cnt);
    end

    // halt on the budget-exhaustion edge of the 30-cycle instance
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    repeat (29) step(0, 0, 0);
    chk_dut("exh.run", 1, 5'b01000, 29);
    step(0, 1, 0);
    chk_dut("exh.drain", 1, 5'b00000, 30);
    repeat (2) step(0, 0, 0);
    chk_dut("exh.done", 1, 5'b10101, 30);

    // zero reset/drain lengths and a tiny budget
    step(1, 0, 0);
    step(0, 0, 0);
    chk_dut("zero.run", 2, 5'b01000, 0);
    repeat (5) step(0, 0, 0);
    chk_dut("zero.to", 2, 5'b10110, 5);
    step(1, 0, 0);
    step(0, 0, 0);
    repeat (2) step(0, 0, 0);
    step(0, 1, 0);
    chk_dut("zero.drain", 2, 5'b00000, 3);
    step(0, 0, 0);
    chk_dut("zero.done", 2, 5'b10101, 3);

    // randomized traffic against the reference model
    for (int k = 0; k < 4000; k++)
      step($urandom_range(199) == 0, $urandom_range(39) == 0,
           $urandom_range(59) == 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
